// File: rtl/arb4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   NREQ      : number of requesters
//   state_e   : arbiter FSM state
//   cnt_width : width of the tenure counter for a given MAXHOLD
package arb4_pkg;

  localparam int unsigned NREQ = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // max(1, clog2(maxhold + 1)); MAXHOLD = 0 still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned maxhold);
    int unsigned w;
    w = $clog2(maxhold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb4_rr_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   req    : request vector, one bit per requester
//   gnt    : registered one-hot grant
//   gnt_id : registered index of the current (or last) owner
//   busy   : registered, high while gnt is non-zero
//   anyreq : combinational OR of req
// master = requester side, slave = arbiter side.
interface arb4_rr_if;
  import arb4_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            busy;
  logic            anyreq;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  anyreq
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output busy,
    output anyreq
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker.
//   req      : request vector
//   ptr      : index with highest priority; scan runs ptr, ptr+1, ... mod 4
//   mask     : requests outside the mask are ignored
//   pick     : one-hot winner (zero when nothing eligible)
//   pick_idx : winner index (zero when nothing eligible)
//   valid    : at least one eligible request
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  input  logic [NREQ-1:0] mask,
  output logic [NREQ-1:0] pick,
  output logic [1:0]      pick_idx,
  output logic            valid
);

  logic [NREQ-1:0] cand;
  logic [1:0]      idx;

  always_comb begin
    cand     = req & mask;
    valid    = |cand;
    pick_idx = 2'd0;
    idx      = 2'd0;
    // Scan from the farthest offset down so the closest candidate to ptr wins.
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (cand[idx]) begin
        pick_idx = idx;
      end
    end
    pick = valid ? (NREQ'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter with grant hold and bounded tenure.
//   clk   : rising-edge clock
//   nrst  : synchronous active-low reset
//   bus   : arb4_rr_if slave port (req in; gnt, gnt_id, busy, anyreq out)
// MAXHOLD bounds how long an owner keeps the grant while someone else waits
// (0 = unbounded). Grant outputs are registered; anyreq is combinational.
module arb4_rr
  import arb4_pkg::*;
#(
  parameter int unsigned MAXHOLD = 8
) (
  input  logic     clk,
  input  logic     nrst,
  arb4_rr_if.slave bus
);

  localparam int unsigned CntW = cnt_width(MAXHOLD);
  localparam logic [CntW-1:0] CntLast = (MAXHOLD == 0) ? '0 : CntW'(MAXHOLD - 1);

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [1:0]      gnt_id_q;
  logic            busy_q;
  logic [1:0]      ptr_q;
  logic [CntW-1:0] cnt_q;

  logic [1:0]      pick_ptr;
  logic [NREQ-1:0] pick_mask;
  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] pick;
  logic [1:0]      pick_idx;
  logic            pick_valid;
  logic            tenure_end;

  // While granted, the owner is masked out and the scan starts just past it, so a
  // valid pick means "another requester is waiting" and is the hand-off target for
  // both release and forced hand-off.
  assign owner_oh   = NREQ'(1) << gnt_id_q;
  assign pick_ptr   = (state_q == GRANT) ? gnt_id_q + 2'd1 : ptr_q;
  assign pick_mask  = (state_q == GRANT) ? ~owner_oh : '1;
  assign tenure_end = (MAXHOLD != 0) && (cnt_q == CntLast);

  rr_pick4 u_pick (
    .req      (bus.req),
    .ptr      (pick_ptr),
    .mask     (pick_mask),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      gnt_id_q <= 2'd0;
      busy_q   <= 1'b0;
      ptr_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q    <= pick;
            gnt_id_q <= pick_idx;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          if (!bus.req[gnt_id_q]) begin
            // Release: hand off directly if anyone else is asking, else go idle.
            ptr_q <= gnt_id_q + 2'd1;
            if (pick_valid) begin
              gnt_q    <= pick;
              gnt_id_q <= pick_idx;
              cnt_q    <= '0;
            end else begin
              gnt_q   <= '0;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end else if (tenure_end && pick_valid) begin
            // Forced hand-off; the preempted owner keeps requesting and rotates back.
            ptr_q    <= gnt_id_q + 2'd1;
            gnt_q    <= pick;
            gnt_id_q <= pick_idx;
            cnt_q    <= '0;
          end else if (tenure_end) begin
            cnt_q <= '0;
          end else if (MAXHOLD != 0) begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;
  assign bus.anyreq = |bus.req;

endmodule

// File: tb/tb_arb4_rr.sv
// Self-checking bench for arb4_rr (MAXHOLD = 4). A behavioural model predicts the
// registered outputs for every cycle; predictions are queued when stimulus is driven
// and compared after the clock edge. Directed checks cover the listed scenarios.
module tb_arb4_rr;

  localparam int unsigned MH = 4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
  } exp_t;

  logic clk;
  logic nrst;

  arb4_rr_if bus ();

  arb4_rr #(
    .MAXHOLD (MH)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Reference model state
  logic [3:0] m_gnt;
  int         m_id;
  logic       m_busy;
  int         m_ptr;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic n);
    int         o;
    int         w;
    logic [3:0] others;
    if (!n) begin
      m_gnt = 4'b0; m_id = 0; m_busy = 1'b0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      w = first_from(r, m_ptr);
      if (w >= 0) begin
        m_id = w; m_gnt = 4'b1 << w; m_busy = 1'b1; m_cnt = 0;
      end
    end else begin
      o      = m_id;
      others = r & ~(4'b1 << o);
      if (!r[o]) begin
        m_ptr = (o + 1) % 4;
        m_cnt = 0;
        if (others != 0) begin
          m_id  = first_from(others, (o + 1) % 4);
          m_gnt = 4'b1 << m_id;
        end else begin
          m_gnt = 4'b0; m_busy = 1'b0;
        end
      end else if (m_cnt == MH - 1) begin
        m_cnt = 0;
        if (others != 0) begin
          m_ptr = (o + 1) % 4;
          m_id  = first_from(others, (o + 1) % 4);
          m_gnt = 4'b1 << m_id;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  // One clock: drive inputs, predict, then compare after the edge.
  task automatic cycle(input logic [3:0] r, input logic n);
    exp_t e;
    @(negedge clk);
    bus.req = r;
    nrst    = n;
    #1 check("anyreq", 32'(bus.anyreq), 32'(|r));
    model_step(r, n);
    e.gnt  = m_gnt;
    e.id   = 2'(m_id);
    e.busy = m_busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_gnt", 32'(bus.gnt), 32'(e.gnt));
    check("sb_gnt_id", 32'(bus.gnt_id), 32'(e.id));
    check("sb_busy", 32'(bus.busy), 32'(e.busy));
  endtask

  task automatic cycle_exp(input string tag, input logic [3:0] r, input logic n,
                           input logic [3:0] exp_gnt);
    cycle(r, n);
    check(tag, 32'(bus.gnt), 32'(exp_gnt));
  endtask

  initial begin
    nrst    = 1'b0;
    bus.req = 4'b0;

    // Reset with all requesting
    cycle_exp("rst_gnt0", 4'b1111, 1'b0, 4'b0000);
    cycle_exp("rst_gnt1", 4'b1111, 1'b0, 4'b0000);
    check("rst_id", 32'(bus.gnt_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    cycle_exp("rst_first", 4'b1111, 1'b1, 4'b0001);

    // Rotation with single-cycle drops
    cycle(4'b0000, 1'b0);
    cycle_exp("rot_a", 4'b1010, 1'b1, 4'b0010);
    cycle_exp("rot_b", 4'b1000, 1'b1, 4'b1000);
    cycle_exp("rot_c", 4'b0010, 1'b1, 4'b0010);
    cycle_exp("rot_hold", 4'b1010, 1'b1, 4'b0010);

    // Forced hand-off every MH cycles
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle_exp("force", 4'b0011, 1'b1, (((i / MH) % 2) == 0) ? 4'b0001 : 4'b0010);
    end

    // Renewal: lone requester keeps the grant
    cycle(4'b0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle_exp("renew", 4'b0100, 1'b1, 4'b0100);
      check("renew_busy", 32'(bus.busy), 32'd1);
    end

    // Release to idle, then a fresh request
    cycle_exp("idle_gnt", 4'b0000, 1'b1, 4'b0000);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_id", 32'(bus.gnt_id), 32'd2);
    cycle_exp("idle_stay", 4'b0000, 1'b1, 4'b0000);
    cycle_exp("idle_regrant", 4'b0001, 1'b1, 4'b0001);

    // Reset mid-tenure
    cycle(4'b0000, 1'b0);
    cycle_exp("mid_g", 4'b1000, 1'b1, 4'b1000);
    cycle(4'b1000, 1'b1);
    cycle(4'b1000, 1'b1);
    cycle_exp("mid_rst", 4'b1000, 1'b0, 4'b0000);
    cycle_exp("mid_after", 4'b1001, 1'b1, 4'b0001);

    // Same-edge raise during release is eligible
    cycle_exp("same_edge", 4'b0100, 1'b1, 4'b0100);

    // Random traffic against the model, with sticky requests and rare resets
    begin
      logic [3:0] r;
      r = 4'b0;
      for (int i = 0; i < 400; i++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
        end
        cycle(r, ($urandom_range(0, 99) != 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
